// File: rtl/div_ratio_ctrl.sv
// div_ratio_ctrl: run-controlled clock divider with glitch-free half-period reconfiguration.
// Define DIV_PERIOD_CNT_EN to build the 16-bit completed-period counter; otherwise period_cnt is 0.
module div_ratio_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             run_en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             clk_div,
  output logic             tick_rise,
  output logic             tick_fall,
  output logic             busy,
  output logic [15:0]      period_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, h, p;
  logic pend, acc, tog, fall;
  // A pending value only lives in RUN/DRAIN; IDLE always accepts straight into h.
  assign cfg_ready = (state == IDLE) || !pend;
  always_comb begin
    acc = cfg_valid && cfg_ready;
    tog = (state != IDLE) && (cnt == h);
    fall = tog && clk_div;
    state_n = state == IDLE ? (run_en ? RUN : IDLE)
            : state == RUN  ? (run_en ? RUN : DRAIN)
            : (fall ? IDLE : DRAIN);
  end
  always_ff @(posedge clk) begin
    if (!n_rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      cnt <= '0;
      h <= CNT_W'(4);
      p <= '0;
      pend <= 1'b0;
      clk_div <= 1'b0;
      tick_rise <= 1'b0;
      tick_fall <= 1'b0;
      busy <= 1'b0;
    end else begin
      busy <= state_n != IDLE;
      tick_rise <= tog && !clk_div;
      tick_fall <= fall;
      if (state == IDLE) begin
        cnt <= '0;
        clk_div <= 1'b0;
        h <= acc ? cfg_half : pend ? p : h;
        pend <= 1'b0;
      end else begin
        cnt <= tog ? '0 : cnt + 1'b1;
        clk_div <= clk_div ^ tog;
        // h only moves on the falling toggle, so a period never changes length midway
        if (acc) begin
          p <= cfg_half;
          pend <= 1'b1;
        end else if (fall && pend) begin
          h <= p;
          pend <= 1'b0;
        end
      end
    end
  end
`ifdef DIV_PERIOD_CNT_EN
  always_ff @(posedge clk) begin
    if (!n_rst) period_cnt <= '0;
    else if (fall) period_cnt <= period_cnt + 1'b1;
  end
`else
  assign period_cnt = '0;
`endif
endmodule

// File: tb/tb_div_ratio_ctrl.sv
// tb_div_ratio_ctrl: vector/scoreboard bench for div_ratio_ctrl (default and DIV_PERIOD_CNT_EN builds).
module tb_div_ratio_ctrl;
  logic clk = 1'b0, n_rst = 1'b0, run_en = 1'b0, cfg_valid = 1'b0;
  logic [7:0] cfg_half = 8'd0;
  logic cfg_ready, clk_div, tick_rise, tick_fall, busy;
  logic [15:0] period_cnt;
  int checks = 0, fails = 0;
  typedef struct {
    logic rst_n, run, valid;
    logic [7:0] half;
    logic [4:0] exp;
  } vec_t;
  vec_t sb[$];
  vec_t tbl[9];

  always #5 clk = ~clk;

  div_ratio_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .n_rst(n_rst), .run_en(run_en), .cfg_valid(cfg_valid), .cfg_half(cfg_half),
    .cfg_ready(cfg_ready), .clk_div(clk_div), .tick_rise(tick_rise), .tick_fall(tick_fall),
    .busy(busy), .period_cnt(period_cnt)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic ru, input logic v, input logic [7:0] hf, input logic [4:0] e);
    vec_t x;
    x.rst_n = r;
    x.run = ru;
    x.valid = v;
    x.half = hf;
    x.exp = e;
    return x;
  endfunction

  // exp bits: {clk_div, tick_rise, tick_fall, busy, cfg_ready}
  task automatic apply(input vec_t v, input string name);
    vec_t e;
    @(negedge clk);
    n_rst = v.rst_n;
    run_en = v.run;
    cfg_valid = v.valid;
    cfg_half = v.half;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check(name, {11'd0, clk_div, tick_rise, tick_fall, busy, cfg_ready}, {11'd0, e.exp});
  endtask

  // Ideal waveform j cycles after RUN entry (j=1 is the entry edge), phases of h+1 cycles,
  // phase b first; even phases low, odd high; ticks on the first cycle of a phase.
  function automatic logic [4:0] wave(input int j, input int h, input int b, input logic bsy, input logic rdy);
    int ph = b + (j - 1) / (h + 1);
    bit first = ((j - 1) % (h + 1)) == 0;
    return {ph[0], first && ph[0], first && !ph[0] && ph > 0, bsy, rdy};
  endfunction

  function automatic logic [15:0] pexp(input int n);
`ifdef DIV_PERIOD_CNT_EN
    return 16'(n);
`else
    return 16'(n * 0);
`endif
  endfunction

  task automatic run_seg(input int n, input int h, input int b, input string name);
    for (int k = 1; k <= n; k++)
      apply(mk(1, 1, 0, 0, wave(k, h, b, 1, 1)), $sformatf("%s j%0d", name, k));
  endtask

  initial begin
    apply(mk(0, 0, 0, 0, 5'b00001), "reset0");
    apply(mk(0, 0, 0, 0, 5'b00001), "reset1");
    check("pc_reset", period_cnt, 16'd0);
    // default divide-by-10, then shrink to divide-by-2 mid-high-phase
    run_seg(28, 4, 0, "div10");
    check("pc_div10", period_cnt, pexp(2));
    apply(mk(1, 1, 1, 8'd0, 5'b10010), "cfg_acc j29");
    apply(mk(1, 1, 0, 8'd0, 5'b10010), "cfg_pend j30");
    run_seg(8, 0, 6, "div2");
    check("pc_div2", period_cnt, pexp(6));
    apply(mk(0, 1, 0, 0, 5'b00001), "rst_mid_high");
    check("pc_after_rst", period_cnt, 16'd0);
    // H back to 4 after reset; drop run_en in the low phase, pulse it during DRAIN
    for (int k = 1; k <= 23; k++)
      apply(mk(1, (k < 14) || (k == 16), 0, 0,
               k <= 20 ? wave(k, 4, 0, 1, 1) : k == 21 ? 5'b00101 : 5'b00001),
            $sformatf("drain j%0d", k));
    check("pc_drain_idle", period_cnt, pexp(2));
    // IDLE accept + run in the same cycle: divide-by-4 from the first period
    tbl[0] = mk(1, 1, 1, 8'd1, 5'b00011);
    tbl[1] = mk(1, 1, 0, 8'd0, 5'b00011);
    tbl[2] = mk(1, 1, 0, 8'd0, 5'b11011);
    tbl[3] = mk(1, 1, 0, 8'd0, 5'b10011);
    tbl[4] = mk(1, 1, 0, 8'd0, 5'b00111);
    tbl[5] = mk(1, 1, 0, 8'd0, 5'b00011);
    tbl[6] = mk(1, 1, 0, 8'd0, 5'b11011);
    tbl[7] = mk(1, 1, 0, 8'd0, 5'b10011);
    tbl[8] = mk(1, 1, 0, 8'd0, 5'b00111);
    for (int i = 0; i < 9; i++) apply(tbl[i], $sformatf("div4 row%0d", i));
    check("pc_div4", period_cnt, pexp(4));
    // period counter wrap at divide-by-2
    apply(mk(0, 0, 0, 0, 5'b00001), "reset_wrap");
    apply(mk(1, 1, 1, 8'd0, 5'b00011), "wrap_entry");
`ifdef DIV_PERIOD_CNT_EN
    repeat (131070) @(posedge clk);
    #1;
    check("pc_ffff", period_cnt, 16'hffff);
    repeat (2) @(posedge clk);
    #1;
    check("pc_wrap0", period_cnt, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    check("pc_wrap1", period_cnt, 16'h0001);
`else
    for (int k = 2; k <= 200; k++) begin
      apply(mk(1, 1, 0, 0, wave(k, 0, 0, 1, 1)), $sformatf("nocnt j%0d", k));
      check($sformatf("pc_zero j%0d", k), period_cnt, 16'd0);
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
